// File: rtl/alu_seq_if.sv
// Request/response handshake bundle for alu_seq: operands and one-hot op in,
// widened result out, each side with its own valid/ready pair.
interface alu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in1;
    logic [XLEN-1:0]   in2;
    logic [12:0]       op;
    logic              out_valid;
    logic              out_ready;
    logic [2*XLEN-1:0] result;

    modport master (
        output in_valid, in1, in2, op, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in1, in2, op, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic ops, iterative unsigned divide/remainder and
// shift-add multiply. Define ALU_FAST_MUL_EN to make mul a single-cycle op instead.
module alu_seq #(
    parameter int unsigned XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned CW = SW + 1;

    localparam logic [12:0] OpAdd  = 13'h0001;
    localparam logic [12:0] OpSub  = 13'h0002;
    localparam logic [12:0] OpXor  = 13'h0004;
    localparam logic [12:0] OpOr   = 13'h0008;
    localparam logic [12:0] OpAnd  = 13'h0010;
    localparam logic [12:0] OpSll  = 13'h0020;
    localparam logic [12:0] OpSrl  = 13'h0040;
    localparam logic [12:0] OpSra  = 13'h0080;
    localparam logic [12:0] OpSlt  = 13'h0100;
    localparam logic [12:0] OpSltu = 13'h0200;
    localparam logic [12:0] OpMul  = 13'h0400;
    localparam logic [12:0] OpDivu = 13'h0800;
    localparam logic [12:0] OpRemu = 13'h1000;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q, state_d;
    logic [2*XLEN-1:0] result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;  // also the multiplicand
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic              rem_sel_q, rem_sel_d;
`ifndef ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
`endif

    logic              accept;
    logic              last;
    logic [SW-1:0]     shamt;
    logic [2*XLEN-1:0] single_res;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;

    assign accept = bus.in_valid && (state_q == StIdle);
    assign last   = (cnt_q == CW'(XLEN - 1));
    assign shamt  = bus.in2[SW-1:0];

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;

    always_comb begin
        single_res = '0;
        unique case (bus.op)
            OpAdd:  single_res[XLEN-1:0] = bus.in1 + bus.in2;
            OpSub:  single_res[XLEN-1:0] = bus.in1 - bus.in2;
            OpXor:  single_res[XLEN-1:0] = bus.in1 ^ bus.in2;
            OpOr:   single_res[XLEN-1:0] = bus.in1 | bus.in2;
            OpAnd:  single_res[XLEN-1:0] = bus.in1 & bus.in2;
            OpSll:  single_res[XLEN-1:0] = bus.in1 << shamt;
            OpSrl:  single_res[XLEN-1:0] = bus.in1 >> shamt;
            OpSra:  single_res[XLEN-1:0] = $signed(bus.in1) >>> shamt;
            OpSlt:  single_res[0] = $signed(bus.in1) < $signed(bus.in2);
            OpSltu: single_res[0] = bus.in1 < bus.in2;
`ifdef ALU_FAST_MUL_EN
            OpMul:  single_res = {{XLEN{1'b0}}, bus.in1} * {{XLEN{1'b0}}, bus.in2};
`endif
            default: single_res = '0;
        endcase
    end

    // Restoring divide step; a zero divisor naturally yields all-ones / dividend.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        if (diff[XLEN]) begin
            rem_step = rem_shift[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_step = diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end
    end

`ifndef ALU_FAST_MUL_EN
    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, divisor_q} : '0);
        prod_step = {mul_sum, prod_q[XLEN-1:1]};
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rem_sel_d = rem_sel_q;
`ifndef ALU_FAST_MUL_EN
        prod_d    = prod_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d     = '0;
                    divisor_d = bus.in2;
                    if (bus.op == OpDivu || bus.op == OpRemu) begin
                        state_d   = StDiv;
                        rem_d     = '0;
                        quo_d     = bus.in1;
                        rem_sel_d = (bus.op == OpRemu);
`ifndef ALU_FAST_MUL_EN
                    end else if (bus.op == OpMul) begin
                        state_d = StMul;
                        prod_d  = {{XLEN{1'b0}}, bus.in1};
`endif
                    end else begin
                        state_d  = StDone;
                        result_d = single_res;
                    end
                end
            end
`ifndef ALU_FAST_MUL_EN
            StMul: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CW'(1);
                if (last) begin
                    state_d  = StDone;
                    result_d = prod_step;
                end
            end
`endif
            StDiv: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = StDone;
                    result_d = {{XLEN{1'b0}}, rem_sel_q ? rem_step : quo_step};
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            result_q  <= '0;
            cnt_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            rem_sel_q <= 1'b0;
`ifndef ALU_FAST_MUL_EN
            prod_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            rem_sel_q <= rem_sel_d;
`ifndef ALU_FAST_MUL_EN
            prod_q    <= prod_d;
`endif
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle successor to the combinational ALU in the execute stage. Takes one operation per valid/ready handshake and returns a registered, widened result with a valid/ready handshake. Single-cycle ops run in one cycle. Divide and remainder, and multiply in the area build, run on an iterative shift datapath. This lets the pipeline stall on long ops instead of closing timing through a full combinational multiplier and divider.

## Interface
- `XLEN`, 32, operand width in bits; legal values are 8, 16, 32, 64.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: block can accept a request; high only in IDLE.
- `in1` input XLEN: first operand.
- `in2` input XLEN: second operand.
- `op` input 13: one-hot operation select.
  - Bit 0 add, bit 1 sub, bit 2 xor, bit 3 or, bit 4 and.
  - Bit 5 sll, bit 6 srl, bit 7 sra, bit 8 slt, bit 9 sltu.
  - Bit 10 mul, bit 11 divu, bit 12 remu.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer accepts `result`.
- `result` output 2*XLEN: registered result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept: request is taken when `in_valid && in_ready`. Operands and `op` are captured on that edge.

Single-cycle ops (bits 0–9, and bit 10 when `ALU_FAST_MUL_EN` is defined)
- Result is computed from the inputs and registered on the accept edge. State goes IDLE→DONE.
- Single-cycle results are XLEN bits, zero-extended to 2*XLEN. add/sub wrap modulo 2^XLEN.
- Shift amount is `in2[log2(XLEN)-1:0]`.
- sra is arithmetic: `in1` is sign-extended.
- slt compares signed; sltu compares unsigned. Both return 0 or 1.

Multiply
- mul is unsigned. The full 2*XLEN product goes to `result`.

Iterative multiply (macro undefined): IDLE→MUL
- Shift-add, one multiplier bit per cycle, XLEN cycles, then →DONE.

Divide / remainder: IDLE→DIV
- Unsigned restoring divide, one quotient bit per cycle, XLEN cycles, then →DONE.
- divu result is the quotient; remu result is the remainder. Both are zero-extended.
- Divide by zero: divu returns all-ones XLEN (zero-extended); remu returns `in1`. Latency is unchanged.

Illegal `op` (zero or more than one bit set)
- Accepted like a single-cycle op; `result` = 0.

DONE
- `out_valid` = 1. `result` is held stable until `out_valid && out_ready`, then →IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready` = 1 (combinational from IDLE)
  - `out_valid` = 0
  - `result` = 0
  - all iteration registers = 0
- Latency is counted from the accept edge to the first cycle `out_valid` = 1:
  - Single-cycle ops: 1 cycle.
  - mul without the macro: XLEN+1 cycles.
  - divu/remu: XLEN+1 cycles.
- Throughput: at most one op per 2 cycles. `in_ready` is 0 in MUL, DIV and DONE.
- Inputs are ignored when `in_ready` = 0. Operands may change freely after the accept edge.
- `out_ready` may be held high in advance; the result drains on the first DONE cycle.
- `rst` asserted in any state, including mid-iteration, forces reset values on the next edge. The in-flight op is discarded and no `out_valid` is produced for it.
- Iteration counter is log2(XLEN)+1 bits wide. It is cleared on accept and must not wrap into a spurious extra cycle.

## Configuration
- `ALU_FAST_MUL_EN` defined:
  - mul is a single-cycle op (latency 1).
  - MUL state and shift-add registers are not built.
- `ALU_FAST_MUL_EN` undefined:
  - mul uses the iterative path (latency XLEN+1).
  - No combinational XLEN×XLEN multiplier is instantiated.
- All other behaviour is identical in both builds.

## Test plan
- Reset, XLEN=32: hold `rst` 2 cycles.
  - Expect `in_ready`=1, `out_valid`=0, `result`=0.
- add, `in1`=0xFFFFFFFF, `in2`=1.
  - Expect `result`=0 (wrap).
  - Expect `out_valid` one cycle after accept.
- sra, `in1`=0x80000000, `in2`=4: expect `result`=0xF8000000.
- slt, `in1`=0xFFFFFFFF, `in2`=1: expect 1.
- sltu with the same operands: expect 0.
- mul, `in1`=0xFFFFFFFF, `in2`=0xFFFFFFFF: expect `result`=0xFFFFFFFE00000001.
  - With the macro: latency 1.
  - Without the macro: latency 33.
- divu 100/7: expect 14 after 33 cycles.
- remu 100/7: expect 2 after 33 cycles.
- divu x/0 with x=0x1234: expect 0xFFFFFFFF.
- remu x/0 with x=0x1234: expect 0x1234.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - Expect `result` stable and `in_ready`=0 throughout.
- Mid-op reset: assert `rst` at cycle 10 of a divu.
  - Expect IDLE and `out_valid`=0.
  - Expect a following add to complete normally.
